// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package reg_file_pkg;

   localparam int M_DEF = 32;
   localparam int N_DEF = 8;

   function automatic int addr_w(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   // An address is usable when it is neither virtual register 0 nor beyond M.
   function automatic logic addr_ok(input int a, input int m);
      return (a != 0) && (a < m);
   endfunction

   typedef logic [addr_w(M_DEF)-1:0] reg_addr_t;
   typedef logic [N_DEF-1:0]         reg_data_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reservations and
// cleared by committed writes, with a same-cycle reservation taking precedence.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int M  = 32,
   parameter int NW = 2,
   localparam int AW = addr_w(M)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rsv_enable,
   input  logic [AW-1:0]          rsv_addr,
   input  logic [NW-1:0]          wr_commit,
   input  logic [NW-1:0][AW-1:0]  wr_addr,
   output logic [M-1:0]           busy_vec
);

   logic [M-1:0] busy_q;
   logic [M-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NW; i++) begin
         if (wr_commit[i]) busy_d[wr_addr[i]] = 1'b0;
      end
      // Applied after the clears so a new producer overrides a retiring one.
      if (rsv_enable && addr_ok(int'(rsv_addr), M)) busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file for the pico-MIPS datapath: NR combinational read
// ports, NW prioritised write ports, optional write bypass and a busy scoreboard.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int M      = 32,
   parameter int N      = 8,
   parameter int NR     = 2,
   parameter int NW     = 2,
   parameter int BYPASS = 1,
   localparam int AW    = addr_w(M)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NR-1:0][AW-1:0] rd_addr,
   output logic [NR-1:0][N-1:0]  rd_data,
   output logic [NR-1:0]         rd_busy,
   input  logic [NW-1:0]         w_enable,
   input  logic [NW-1:0][AW-1:0] w_addr,
   input  logic [NW-1:0][N-1:0]  Wdata,
   input  logic                  rsv_enable,
   input  logic [AW-1:0]         rsv_addr,
   output logic [M-1:0]          busy_vec,
   output logic                  w_conflict
);

   logic [NW-1:0]        w_commit;
   logic [M-1:0][N-1:0]  regs_flat;
   logic                 w_conflict_q;
   logic                 w_conflict_d;

   always_comb begin
      w_commit = '0;
      for (int i = 0; i < NW; i++) begin
         w_commit[i] = w_enable[i] && addr_ok(int'(w_addr[i]), M);
      end
   end

   assign regs_flat[0] = '0;

   generate
      for (genvar r = 1; r < M; r++) begin : g_reg
         logic [N-1:0] data_q;
         logic [N-1:0] data_d;
         logic         we_d;

         // Later ports overwrite earlier matches, so the highest index wins.
         always_comb begin
            we_d   = 1'b0;
            data_d = data_q;
            for (int i = 0; i < NW; i++) begin
               if (w_commit[i] && (w_addr[i] == AW'(r))) begin
                  we_d   = 1'b1;
                  data_d = Wdata[i];
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst)       data_q <= '0;
            else if (we_d) data_q <= data_d;
         end

         assign regs_flat[r] = data_q;
      end
   endgenerate

   always_comb begin
      w_conflict_d = 1'b0;
      for (int i = 0; i < NW; i++) begin
         for (int k = i + 1; k < NW; k++) begin
            if (w_commit[i] && w_commit[k] && (w_addr[i] == w_addr[k])) w_conflict_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) w_conflict_q <= 1'b0;
      else     w_conflict_q <= w_conflict_d;
   end

   assign w_conflict = w_conflict_q;

   generate
      for (genvar j = 0; j < NR; j++) begin : g_rd
         logic [N-1:0] data_w;
         logic         busy_w;

         always_comb begin
            data_w = '0;
            busy_w = 1'b0;
            if (!rst && addr_ok(int'(rd_addr[j]), M)) begin
               data_w = regs_flat[rd_addr[j]];
               busy_w = busy_vec[rd_addr[j]];
               if (BYPASS != 0) begin
                  for (int i = 0; i < NW; i++) begin
                     if (w_commit[i] && (w_addr[i] == rd_addr[j])) begin
                        data_w = Wdata[i];
                        busy_w = 1'b0;
                     end
                  end
               end
            end
         end

         assign rd_data[j] = data_w;
         assign rd_busy[j] = busy_w;
      end
   endgenerate

   reg_scoreboard #(
      .M  (M),
      .NW (NW)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .rsv_enable (rsv_enable),
      .rsv_addr   (rsv_addr),
      .wr_commit  (w_commit),
      .wr_addr    (w_addr),
      .busy_vec   (busy_vec)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing and one non-bypassing instance
// share every input, and their outputs are compared against a vector table.
module tb_reg_file_mp;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0][4:0] rd_addr;
   logic [1:0]      w_enable;
   logic [1:0][4:0] w_addr;
   logic [1:0][7:0] Wdata;
   logic            rsv_enable;
   logic [4:0]      rsv_addr;

   logic [1:0][7:0] rd_data_b, rd_data_n;
   logic [1:0]      rd_busy_b, rd_busy_n;
   logic [31:0]     busy_vec_b, busy_vec_n;
   logic            conf_b, conf_n;

   reg_file_mp #(.M(32), .N(8), .NR(2), .NW(2), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .w_enable(w_enable), .w_addr(w_addr), .Wdata(Wdata), .rsv_enable(rsv_enable),
      .rsv_addr(rsv_addr), .busy_vec(busy_vec_b), .w_conflict(conf_b)
   );

   reg_file_mp #(.M(32), .N(8), .NR(2), .NW(2), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .w_enable(w_enable), .w_addr(w_addr), .Wdata(Wdata), .rsv_enable(rsv_enable),
      .rsv_addr(rsv_addr), .busy_vec(busy_vec_n), .w_conflict(conf_n)
   );

   typedef struct {
      logic [1:0] we;
      logic [4:0] wa0, wa1;
      logic [7:0] wd0, wd1;
      logic       rsv;
      logic [4:0] ra;
      logic [4:0] r0, r1;
      logic [7:0] eb0, eb1, en0, en1;
      logic [1:0] ebusy, enbusy;
      logic       econf;
   } vec_t;

   vec_t vecs [17];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      w_enable   = v.we;
      w_addr[0]  = v.wa0;
      w_addr[1]  = v.wa1;
      Wdata[0]   = v.wd0;
      Wdata[1]   = v.wd1;
      rsv_enable = v.rsv;
      rsv_addr   = v.ra;
      rd_addr[0] = v.r0;
      rd_addr[1] = v.r1;
   endtask

   task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
      w_enable   = 2'b00;
      w_addr     = '0;
      Wdata      = '0;
      rsv_enable = 1'b0;
      rsv_addr   = 5'd0;
      rd_addr[0] = r0;
      rd_addr[1] = r1;
   endtask

   initial begin
      //           we     wa0    wa1    wd0    wd1    rsv   ra      r0     r1     eb0    eb1    en0    en1    ebusy  enbusy conf
      vecs[0]  = '{2'b11, 5'd3,  5'd4,  8'h11, 8'h22, 1'b0, 5'd0,  5'd3,  5'd4,  8'h11, 8'h22, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
      vecs[1]  = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd3,  5'd4,  8'h11, 8'h22, 8'h11, 8'h22, 2'b00, 2'b00, 1'b0};
      vecs[2]  = '{2'b11, 5'd7,  5'd7,  8'h01, 8'h02, 1'b0, 5'd0,  5'd7,  5'd3,  8'h02, 8'h11, 8'h00, 8'h11, 2'b00, 2'b00, 1'b0};
      vecs[3]  = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd7,  5'd0,  8'h02, 8'h00, 8'h02, 8'h00, 2'b00, 2'b00, 1'b1};
      vecs[4]  = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd7,  5'd4,  8'h02, 8'h22, 8'h02, 8'h22, 2'b00, 2'b00, 1'b0};
      vecs[5]  = '{2'b01, 5'd9,  5'd0,  8'h5A, 8'h00, 1'b0, 5'd0,  5'd9,  5'd9,  8'h5A, 8'h5A, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
      vecs[6]  = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd9,  5'd7,  8'h5A, 8'h02, 8'h5A, 8'h02, 2'b00, 2'b00, 1'b0};
      vecs[7]  = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b1, 5'd12, 5'd12, 5'd12, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
      vecs[8]  = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd12, 5'd3,  8'h00, 8'h11, 8'h00, 8'h11, 2'b01, 2'b01, 1'b0};
      vecs[9]  = '{2'b10, 5'd0,  5'd12, 8'h00, 8'hC3, 1'b0, 5'd0,  5'd12, 5'd12, 8'hC3, 8'hC3, 8'h00, 8'h00, 2'b00, 2'b11, 1'b0};
      vecs[10] = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd12, 5'd12, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 2'b00, 2'b00, 1'b0};
      vecs[11] = '{2'b01, 5'd12, 5'd0,  8'h44, 8'h00, 1'b1, 5'd12, 5'd12, 5'd12, 8'h44, 8'h44, 8'hC3, 8'hC3, 2'b00, 2'b00, 1'b0};
      vecs[12] = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd12, 5'd12, 8'h44, 8'h44, 8'h44, 8'h44, 2'b11, 2'b11, 1'b0};
      vecs[13] = '{2'b11, 5'd0,  5'd0,  8'hFF, 8'hFF, 1'b0, 5'd0,  5'd0,  5'd0,  8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
      vecs[14] = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd0,  5'd12, 8'h00, 8'h44, 8'h00, 8'h44, 2'b10, 2'b10, 1'b0};
      vecs[15] = '{2'b11, 5'd5,  5'd6,  8'h66, 8'h77, 1'b1, 5'd0,  5'd5,  5'd6,  8'h66, 8'h77, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
      vecs[16] = '{2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 1'b0, 5'd0,  5'd5,  5'd6,  8'h66, 8'h77, 8'h66, 8'h77, 2'b00, 2'b00, 1'b0};

      // Reset state, and a write attempted while reset is held.
      rst = 1'b0;
      idle(5'd5, 5'd0);
      #1 rst = 1'b1;
      #1;
      chk("reset busy_vec_b", busy_vec_b, 32'h0);
      chk("reset busy_vec_n", busy_vec_n, 32'h0);
      chk("reset conf_b", 32'(conf_b), 32'h0);
      w_enable  = 2'b01;
      w_addr[0] = 5'd5;
      Wdata[0]  = 8'hAA;
      #1;
      chk("reset rd0_byp", 32'(rd_data_b[0]), 32'h0);
      chk("reset busy_b", 32'(rd_busy_b), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(5'd5, 5'd0);
      #1;
      chk("write under reset rd0_byp", 32'(rd_data_b[0]), 32'h0);
      chk("write under reset rd0_nb", 32'(rd_data_n[0]), 32'h0);

      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         drive(vecs[k]);
         #1;
         chk($sformatf("v%0d rd0_byp", k), 32'(rd_data_b[0]), 32'(vecs[k].eb0));
         chk($sformatf("v%0d rd1_byp", k), 32'(rd_data_b[1]), 32'(vecs[k].eb1));
         chk($sformatf("v%0d rd0_nb", k), 32'(rd_data_n[0]), 32'(vecs[k].en0));
         chk($sformatf("v%0d rd1_nb", k), 32'(rd_data_n[1]), 32'(vecs[k].en1));
         chk($sformatf("v%0d busy_byp", k), 32'(rd_busy_b), 32'(vecs[k].ebusy));
         chk($sformatf("v%0d busy_nb", k), 32'(rd_busy_n), 32'(vecs[k].enbusy));
         chk($sformatf("v%0d conf_byp", k), 32'(conf_b), 32'(vecs[k].econf));
         chk($sformatf("v%0d conf_nb", k), 32'(conf_n), 32'(vecs[k].econf));
      end

      // Load a collision so w_conflict is high when reset lands mid-cycle.
      @(negedge clk);
      idle(5'd12, 5'd8);
      w_enable = 2'b11;
      w_addr[0] = 5'd8;
      w_addr[1] = 5'd8;
      Wdata[0]  = 8'hAA;
      Wdata[1]  = 8'hBB;
      #1;
      chk("collide8 rd1_byp", 32'(rd_data_b[1]), 32'hBB);
      @(negedge clk);
      idle(5'd12, 5'd8);
      #1;
      chk("pre-rst busy_vec_b", busy_vec_b, 32'h0000_1000);
      chk("pre-rst busy_vec_n", busy_vec_n, 32'h0000_1000);
      chk("pre-rst conf_b", 32'(conf_b), 32'h1);
      chk("pre-rst rd0_byp", 32'(rd_data_b[0]), 32'h44);
      chk("pre-rst rd1_nb", 32'(rd_data_n[1]), 32'hBB);
      #1 rst = 1'b1;
      #1;
      chk("async rst busy_vec_b", busy_vec_b, 32'h0);
      chk("async rst busy_vec_n", busy_vec_n, 32'h0);
      chk("async rst conf_b", 32'(conf_b), 32'h0);
      chk("async rst conf_n", 32'(conf_n), 32'h0);
      chk("async rst rd_byp", 32'(rd_data_b), 32'h0);
      chk("async rst rd_nb", 32'(rd_data_n), 32'h0);
      chk("async rst busy_byp", 32'(rd_busy_b), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post-rst rd_byp", 32'(rd_data_b), 32'h0);
      chk("post-rst rd_nb", 32'(rd_data_n), 32'h0);
      chk("post-rst busy_nb", 32'(rd_busy_n), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
